io_port_ctrl: RTL and testbench
===============================

# io_port_ctrl

Peripheral-side responder for the CPU's IN/OUT instructions. It accepts OUT words from the execution stage into a small FIFO and drains them to an external device over a valid/ready channel. It also buffers one word from an external input device for the next IN instruction. It sits between the execution block's data_out/data_in ports and the board-level I/O pins, and it stalls the pipeline when a transfer cannot complete.

## Interface
- DEPTH, 4, OUT FIFO depth in words; power of two, minimum 2.
- WIDTH, 16, data word width.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- out_wr  in  1  OUT write strobe from the pipeline; held high until accepted.
- out_data  in  WIDTH  OUT word; connects to the execution block's data_out.
- in_rd  in  1  IN read strobe from the pipeline; held high until served.
- data_in  out  WIDTH  IN word; connects to the execution block's data_in.
- stall  out  1  pipeline hold request (combinational).
- ext_out_data  out  WIDTH  word presented to the external sink.
- ext_out_valid  out  1  ext_out_data is valid.
- ext_out_ready  in  1  external sink accepts the word.
- ext_in_data  in  WIDTH  word from the external source.
- ext_in_valid  in  1  ext_in_data is valid.
- ext_in_ready  out  1  block can accept an input word.
- out_cnt  out  16  count of words transmitted (see Configuration).
- in_cnt  out  16  count of words received (see Configuration).

## Operation
**OUT FIFO**
- Circular buffer with DEPTH entries.
- Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- empty = pointers equal. full = low bits equal and MSBs differ.
- Push when out_wr && (!full || ext_out_ready). Pop when ext_out_valid && ext_out_ready.
- Push and pop in the same cycle:
  - Both occur; occupancy is unchanged.
  - When full, the slot being popped is reused and the entry is written after the read.
- ext_out_valid = !empty.
- ext_out_data = mem[rd_ptr] when not empty, otherwise 0.

**Input holder**
- Two-state FSM: EMPTY and FULL.
- EMPTY -> FULL when ext_in_valid && ext_in_ready; hold_reg captures ext_in_data.
- FULL -> EMPTY when in_rd is high.
- ext_in_ready = (state == EMPTY) && !reset.
- data_in:
  - hold_reg when FULL.
  - ext_in_data when EMPTY and ext_in_valid (bypass).
  - Otherwise the last value driven.
- Bypass read (in_rd && EMPTY && ext_in_valid):
  - The handshake completes with the source.
  - The word is not stored; state stays EMPTY; stall stays 0.

**Stall**
- stall = (out_wr && full && !ext_out_ready) || (in_rd && state == EMPTY && !ext_in_valid).

**Reset** (asynchronous, takes effect immediately)
- Pointers and FIFO memory cleared; state forced to EMPTY.
- hold_reg = 0, data_in = 0, counters = 0.
- ext_out_valid = 0, ext_out_data = 0, ext_in_ready = 0, stall = 0.
- Words in flight are discarded.
- A handshake in progress when reset asserts is abandoned; the external device must retry.

## Timing
- OUT latency: a word accepted at edge N gives ext_out_valid high after edge N.
  - It is transferred at the first subsequent edge with ext_out_ready high.
- ext_out_data is stable while ext_out_valid && !ext_out_ready.
- Input capture: a word captured at edge N is available on data_in after edge N.
- stall responds in the same cycle as its inputs and never depends on its own previous value.
- Back-to-back OUT writes stream at one word per cycle while the sink holds ext_out_ready high.
- After reset deasserts, ext_in_ready rises combinationally; the first capture is possible at the next edge.

## Configuration
- Macro: IO_PORT_CTRL_STATS_EN.
- When defined:
  - out_cnt increments on each pop; in_cnt increments on each input handshake, including bypass.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Both clear on reset.
- When undefined:
  - No counter logic is built.
  - out_cnt and in_cnt are tied to 16'h0000; the port list is unchanged.

## Test plan
- **Reset mid-transfer:** reset, then out_wr with out_data=16'h00A5 and ext_out_ready=1.
  - Expect ext_out_valid high and ext_out_data=16'h00A5 one edge later, cleared on the transfer edge.
  - Assert reset while a second word is pending; ext_out_valid drops immediately.
- **Fill and back-pressure:** with ext_out_ready=0, write 4 words 16'h0001..16'h0004.
  - A fifth out_wr gives stall=1.
  - Raise ext_out_ready; expect the fifth write accepted on that edge and words drained in order 0001..0005.
- **Full with simultaneous pop:** FIFO full, out_wr and ext_out_ready both high.
  - Expect stall=0 and occupancy to remain 4.
- **Buffered IN:** ext_in_valid with 16'hBEEF while EMPTY.
  - Expect capture and ext_in_ready=0.
  - A later in_rd gives data_in=16'hBEEF, stall=0, and state EMPTY after the edge.
- **IN stall and bypass:** in_rd with the holder EMPTY and ext_in_valid=0.
  - Expect stall=1.
  - Assert ext_in_valid with 16'h1234; stall drops the same cycle and data_in=16'h1234.
- **Stats counters (IO_PORT_CTRL_STATS_EN defined):** after 3 OUT pops and 2 input handshakes, expect out_cnt=3 and in_cnt=2.
  - Preload a counter to 16'hFFFF by forcing; another event leaves it at 16'hFFFF.

Source files
------------

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: OUT FIFO toward an external sink, plus a one-word IN holder
// fed by an external source, with combinational pipeline stall.
// Optional build macro: IO_PORT_CTRL_STATS_EN adds saturating transfer counters.
module io_port_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_wr,
  input  logic [WIDTH-1:0] out_data,
  input  logic             in_rd,
  output logic [WIDTH-1:0] data_in,
  output logic             stall,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic [15:0]      out_cnt,
  output logic [15:0]      in_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} hold_st_e;

  logic [AW:0]                 wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        full, empty, push, pop;

  hold_st_e                    state_q, state_d;
  logic [WIDTH-1:0]            hold_q, hold_d;
  logic [WIDTH-1:0]            last_q;
  logic                        in_hs;

  // Extra pointer MSB separates the wrapped-full case from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = ext_out_valid && ext_out_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push  = out_wr && (!full || ext_out_ready);

  assign ext_out_valid = !empty;
  assign ext_out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage and pointers; on full+pop the head slot is read before being rewritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= out_data;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign ext_in_ready = (state_q == S_EMPTY) && !reset;
  assign in_hs        = ext_in_valid && ext_in_ready;

  // Holder next state: a read coinciding with an arriving word bypasses storage.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_EMPTY: if (in_hs && !in_rd) begin
        state_d = S_FULL;
        hold_d  = ext_in_data;
      end
      S_FULL:  if (in_rd) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Holder state, captured word, and the last value presented on data_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      hold_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= data_in;
    end
  end

  // IN word: stored word, else live bypass, else keep the previous value.
  always_comb begin
    data_in = last_q;
    if (reset)                        data_in = '0;
    else if (state_q == S_FULL)       data_in = hold_q;
    else if (ext_in_valid)            data_in = ext_in_data;
  end

  assign stall = !reset &&
                 ((out_wr && full && !ext_out_ready) ||
                  (in_rd && (state_q == S_EMPTY) && !ext_in_valid));

`ifdef IO_PORT_CTRL_STATS_EN
  logic [15:0] out_cnt_q, in_cnt_q;

  // Saturating event counters; bypass reads count as input handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt_q <= '0;
      in_cnt_q  <= '0;
    end else begin
      if (pop   && out_cnt_q != 16'hFFFF) out_cnt_q <= out_cnt_q + 16'd1;
      if (in_hs && in_cnt_q  != 16'hFFFF) in_cnt_q  <= in_cnt_q + 16'd1;
    end
  end

  assign out_cnt = out_cnt_q;
  assign in_cnt  = in_cnt_q;
`else
  assign out_cnt = 16'h0000;
  assign in_cnt  = 16'h0000;
`endif
endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: queue-based reference model compared every
// negedge, plus hand-computed literal checks from the stimulus process.
module tb_io_port_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             out_wr, in_rd, ext_out_ready, ext_in_valid;
  logic [WIDTH-1:0] out_data, ext_in_data;
  logic [WIDTH-1:0] data_in, ext_out_data;
  logic             stall, ext_out_valid, ext_in_ready;
  logic [15:0]      out_cnt, in_cnt;

  int n_vec = 0;
  int n_bad = 0;

  io_port_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .out_wr(out_wr), .out_data(out_data),
    .in_rd(in_rd), .data_in(data_in), .stall(stall),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready), .ext_in_data(ext_in_data),
    .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .out_cnt(out_cnt), .in_cnt(in_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk1(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  bit               m_full;
  logic [WIDTH-1:0] m_hold, m_last;
  logic [15:0]      m_ocnt, m_icnt;
  bit               running = 1'b1;

  // Model: expected outputs from current inputs, then advance to the next edge.
  always @(negedge clk) begin
    logic             e_ov, e_ir, e_st;
    logic [WIDTH-1:0] e_od, e_di;
    logic [15:0]      e_oc, e_ic;
    if (running) begin
      if (reset) begin
        m_q.delete(); m_full = 0; m_hold = '0; m_last = '0; m_ocnt = '0; m_icnt = '0;
        e_ov = 0; e_od = '0; e_ir = 0; e_st = 0; e_di = '0;
      end else begin
        e_ov = (m_q.size() != 0);
        e_od = e_ov ? m_q[0] : '0;
        e_ir = !m_full;
        e_di = m_full ? m_hold : (ext_in_valid ? ext_in_data : m_last);
        e_st = (out_wr && m_q.size() == DEPTH && !ext_out_ready) ||
               (in_rd && !m_full && !ext_in_valid);
      end
`ifdef IO_PORT_CTRL_STATS_EN
      e_oc = m_ocnt; e_ic = m_icnt;
`else
      e_oc = 16'h0; e_ic = 16'h0;
`endif
      chk1 ("m_ext_out_valid", ext_out_valid, e_ov);
      chk16("m_ext_out_data",  ext_out_data,  e_od);
      chk1 ("m_ext_in_ready",  ext_in_ready,  e_ir);
      chk16("m_data_in",       data_in,       e_di);
      chk1 ("m_stall",         stall,         e_st);
      chk16("m_out_cnt",       out_cnt,       e_oc);
      chk16("m_in_cnt",        in_cnt,        e_ic);
      if (!reset) begin
        bit do_pop, do_push;
        m_last  = e_di;
        do_pop  = (m_q.size() != 0) && ext_out_ready;
        do_push = out_wr && (m_q.size() < DEPTH || ext_out_ready);
        if (do_pop) begin
          void'(m_q.pop_front());
          if (m_ocnt != 16'hFFFF) m_ocnt++;
        end
        if (do_push) m_q.push_back(out_data);
        if (!m_full) begin
          if (ext_in_valid) begin
            if (m_icnt != 16'hFFFF) m_icnt++;
            if (!in_rd) begin m_full = 1; m_hold = ext_in_data; end
          end
        end else if (in_rd) m_full = 0;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; out_wr = 0; in_rd = 1; ext_out_ready = 0; ext_in_valid = 1;
    out_data = '0; ext_in_data = 16'h7777;
    step(2);
    // Reset holds every output low even with a valid source and a pending read
    chk1 ("rst_in_ready", ext_in_ready, 1'b0);
    chk16("rst_data_in",  data_in, 16'h0);
    chk1 ("rst_stall",    stall, 1'b0);
    chk1 ("rst_out_valid", ext_out_valid, 1'b0);
    in_rd = 0; ext_in_valid = 0; ext_in_data = '0;
    step(1);
    reset = 0;
    #1 chk1("post_rst_in_ready", ext_in_ready, 1'b1);

    // Reset mid-transfer
    out_wr = 1; out_data = 16'h00A5; ext_out_ready = 1;
    step(1);
    out_wr = 0;
    chk1 ("t1_valid", ext_out_valid, 1'b1);
    chk16("t1_data",  ext_out_data, 16'h00A5);
    step(1);
    chk1 ("t1_drained", ext_out_valid, 1'b0);
    ext_out_ready = 0; out_wr = 1; out_data = 16'h0BAD;
    step(1);
    out_wr = 0;
    chk1 ("t1_pending", ext_out_valid, 1'b1);
    reset = 1;
    #1;
    chk1 ("t1_rst_valid", ext_out_valid, 1'b0);
    chk16("t1_rst_data",  ext_out_data, 16'h0);
    step(1);
    reset = 0;

    // Fill and back-pressure
    for (int i = 1; i <= 4; i++) begin
      out_data = 16'(i); out_wr = 1;
      step(1);
    end
    out_data = 16'h0005;
    #1 chk1("t2_stall", stall, 1'b1);
    step(1);
    chk1 ("t2_stall_hold", stall, 1'b1);
    chk16("t2_head", ext_out_data, 16'h0001);
    ext_out_ready = 1;
    #1 chk1("t2_stall_clr", stall, 1'b0);
    step(1);
    out_wr = 0;
    for (int i = 2; i <= 5; i++) begin
      chk16("t2_order", ext_out_data, 16'(i));
      step(1);
    end
    chk1("t2_empty", ext_out_valid, 1'b0);

    // Full with simultaneous pop
    ext_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      out_data = 16'h0010 + 16'(i); out_wr = 1;
      step(1);
    end
    out_data = 16'h0014; ext_out_ready = 1;
    #1 chk1("t3_no_stall", stall, 1'b0);
    step(1);
    out_wr = 0; ext_out_ready = 0;
    chk16("t3_head", ext_out_data, 16'h0011);
    out_wr = 1; out_data = 16'h0099;
    #1 chk1("t3_still_full", stall, 1'b1);
    out_wr = 0; ext_out_ready = 1;
    step(4);
    chk1("t3_empty", ext_out_valid, 1'b0);
    ext_out_ready = 0;

    // Buffered IN
    ext_in_valid = 1; ext_in_data = 16'hBEEF;
    #1 chk1("t4_ready", ext_in_ready, 1'b1);
    step(1);
    ext_in_valid = 0; ext_in_data = 16'h0;
    chk1 ("t4_captured", ext_in_ready, 1'b0);
    chk16("t4_data", data_in, 16'hBEEF);
    step(2);
    in_rd = 1;
    #1;
    chk16("t4_rd_data", data_in, 16'hBEEF);
    chk1 ("t4_rd_stall", stall, 1'b0);
    step(1);
    in_rd = 0;
    chk1 ("t4_empty_again", ext_in_ready, 1'b1);
    chk16("t4_last", data_in, 16'hBEEF);

    // IN stall and bypass
    in_rd = 1;
    #1 chk1("t5_stall", stall, 1'b1);
    step(1);
    chk1("t5_stall_hold", stall, 1'b1);
    ext_in_valid = 1; ext_in_data = 16'h1234;
    #1;
    chk1 ("t5_bypass_stall", stall, 1'b0);
    chk16("t5_bypass_data", data_in, 16'h1234);
    step(1);
    in_rd = 0; ext_in_valid = 0; ext_in_data = '0;
    chk1 ("t5_still_empty", ext_in_ready, 1'b1);
    chk16("t5_last", data_in, 16'h1234);

    // Stats: 3 streamed OUT words, one buffered and one bypassed IN word
    reset = 1;
    step(1);
    reset = 0; ext_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      out_wr = 1; out_data = 16'h0021 + 16'(i);
      step(1);
      chk16("t6_stream", ext_out_data, 16'h0021 + 16'(i));
    end
    out_wr = 0;
    ext_in_valid = 1; ext_in_data = 16'h0042;
    step(1);
    ext_in_valid = 0; in_rd = 1;
    step(1);
    ext_in_valid = 1; ext_in_data = 16'h0043;
    step(1);
    in_rd = 0; ext_in_valid = 0;
`ifdef IO_PORT_CTRL_STATS_EN
    chk16("t6_out_cnt", out_cnt, 16'd3);
    chk16("t6_in_cnt",  in_cnt,  16'd2);
    force dut.out_cnt_q = 16'hFFFF;
    m_ocnt = 16'hFFFF;
    step(1);
    release dut.out_cnt_q;
    out_wr = 1; out_data = 16'h0055;
    step(1);
    out_wr = 0;
    step(1);
    chk16("t6_sat", out_cnt, 16'hFFFF);
`else
    chk16("t6_out_cnt_off", out_cnt, 16'd0);
    chk16("t6_in_cnt_off",  in_cnt,  16'd0);
`endif
    step(2);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
